if_fetch: RTL and testbench
===========================

# if_fetch

Instruction fetch stage of the five-stage pipeline. Owns the program counter, issues single-outstanding requests to instruction memory over a req/ack handshake, buffers returned instructions in a 2-entry queue, and presents them with their addresses to the if_id register feeding the decoder. It redirects on EX-stage jumps, discards stale in-flight fetches, and honours pipeline hold flags.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INST, 32'h0000_0013, instruction driven when no valid instruction is available (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state on rising edge.
- arst  in  1  reset, asynchronous, active-high.
- jump_ena_i  in  1  EX-stage redirect request.
- jump_addr_i  in  32  redirect target; bits [1:0] are ignored and treated as 0.
- hold_i  in  4  hold flags. [0] stalls new fetch issue; [1] stalls output to if_id; [3:2] reserved, ignored.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  32  fetch address; word aligned.
- imem_ack_i  in  1  memory accepts the request; imem_rdata_i is valid in the same cycle.
- imem_rdata_i  in  32  fetched instruction.
- inst_o  out  32  instruction to if_id.
- inst_addr_o  out  32  address of inst_o.
- inst_valid_o  out  1  inst_o/inst_addr_o hold a real instruction.

## Operation
- Reset values: pc=RESET_PC, FSM=IDLE, queue empty, imem_req_o=0, imem_addr_o=RESET_PC, inst_o=NOP_INST, inst_addr_o=0, inst_valid_o=0.
- FSM states: IDLE, REQ, DROP.
  - IDLE: imem_req_o=0. Moves to REQ when queue count<2 and hold_i[0]=0. A jump in IDLE loads pc=jump_addr_i and flushes the queue.
  - REQ: imem_req_o=1, imem_addr_o=pc; address is stable until ack.
    - Ack without jump: push {pc, imem_rdata_i}; pc+=4 (mod 2^32, wraps to 0). Stay in REQ if the post-push count is <2 and hold_i[0]=0, else go to IDLE.
    - Jump with ack in the same cycle: discard the data, pc=jump target, flush, stay in REQ.
    - Jump without ack: pc=jump target, flush, go to DROP.
  - DROP: imem_req_o=1 with the old address held until ack. On ack, discard the data and go to REQ (or IDLE if hold_i[0]). A further jump in DROP overwrites the target (latest wins) and flushes again.
- hold_i[0] never withdraws an asserted request; it only blocks starting a new one. A jump overrides hold_i[0] for pc update and flush.
- Queue:
  - 2 entries of {addr, inst}. The head drives the outputs: inst_valid_o=1 when non-empty; otherwise inst_o=NOP_INST, inst_addr_o=0.
  - Pop each cycle the queue is non-empty and hold_i[1]=0.
  - Push and pop in the same cycle leaves count unchanged.
  - A push while full cannot occur by construction; an assertion flags it.
  - Flush (jump) empties the queue and overrides any same-cycle push or pop.

## Timing
- First request in the first cycle after reset deassertion, addressed RESET_PC.
- Fetch latency: ack in cycle N puts the instruction on inst_o with valid=1 from cycle N+1.
- Zero-wait memory with hold_i=0 gives one instruction per cycle.
- Jump sampled in cycle N:
  - Outputs show NOP/valid=0 from N+1.
  - A request for the target is issued in N+1 if no ack is pending, otherwise in the cycle after the stale ack.
- hold_i[1] freezes the outputs; the queue fills to 2, then the FSM idles. Releasing hold resumes fetch the cycle after count drops below 2.
- Reset asserted mid-transaction aborts immediately; no ack is expected afterwards.

## Test plan
- Reset release, RESET_PC=0, zero-wait ack -> imem_addr_o 0,4,8 on consecutive cycles; inst_o follows one cycle later with matching inst_addr_o, valid=1.
- 3-cycle ack latency -> imem_addr_o holds 0x0 for 3 cycles; exactly one push per ack; inst_valid_o pulses once per fetch.
- hold_i[1]=1 for 6 cycles -> queue holds 0x0, 0x4; imem_req_o drops; outputs frozen on 0x0. On release, 0x0 then 0x4, then fetch of 0x8 resumes.
- Jump to 0x100 while a request to 0x8 is outstanding (ack 2 cycles later) -> 0x8 data discarded; next request 0x100; no instruction at 0x8 ever shows valid.
- Jump coincident with ack, then a second jump to 0x200 during DROP -> both stale fetches dropped; next address 0x200; valid=0 until the 0x200 data arrives.
- PC=0xFFFF_FFFC fetch -> next request address 0x0000_0000; arst pulsed mid-REQ -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/if_fetch_if.sv
// Instruction-memory request bus between the fetch stage and memory.
// Single outstanding request; ack and rdata arrive in the same cycle.
interface if_fetch_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ack_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ack_i,
        output imem_rdata_i
    );
endinterface

// File: rtl/if_fetch.sv
// Fetch stage: PC, single-outstanding imem requests, 2-entry queue to if_id.
// Redirects on EX jumps and drops fetches that were in flight at the jump.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        jump_ena_i,
    input  logic [31:0] jump_addr_i,
    input  logic [3:0]  hold_i,
    if_fetch_if.master  imem,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o
);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t      state;
    logic        req_q;
    logic [31:0] pc;
    logic [31:0] addr_q;
    logic [31:0] q_addr [2];
    logic [31:0] q_inst [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;

    logic [31:0] jump_tgt;
    logic [31:0] pc_inc;
    logic [31:0] pc_drop;
    logic        ack;
    logic        push;
    logic        pop;
    logic [1:0]  count_nxt;
    logic        unused_bits;

    assign jump_tgt    = {jump_addr_i[31:2], 2'b00};
    assign pc_inc      = pc + 32'd4;
    assign pc_drop     = jump_ena_i ? jump_tgt : pc;
    assign ack         = imem.imem_ack_i;
    assign push        = (state == REQ) && ack && !jump_ena_i;
    assign pop         = (count != 2'd0) && !hold_i[1];
    assign count_nxt   = count + {1'b0, push} - {1'b0, pop};
    assign unused_bits = ^{hold_i[3:2], jump_addr_i[1:0]};

    // addr_q tracks pc except in DROP, where it keeps the stale address
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state  <= IDLE;
            req_q  <= 1'b0;
            pc     <= RESET_PC;
            addr_q <= RESET_PC;
        end else begin
            unique case (state)
                IDLE: begin
                    if (jump_ena_i) begin
                        pc     <= jump_tgt;
                        addr_q <= jump_tgt;
                    end
                    if (!hold_i[0] && (jump_ena_i || count != 2'd2)) begin
                        state <= REQ;
                        req_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (jump_ena_i) begin
                        pc <= jump_tgt;
                        if (ack) addr_q <= jump_tgt;
                        else     state  <= DROP;
                    end else if (ack) begin
                        pc     <= pc_inc;
                        addr_q <= pc_inc;
                        if (hold_i[0] || count_nxt == 2'd2) begin
                            state <= IDLE;
                            req_q <= 1'b0;
                        end
                    end
                end
                DROP: begin
                    if (jump_ena_i) pc <= jump_tgt;
                    if (ack) begin
                        addr_q <= pc_drop;
                        if (hold_i[0]) begin
                            state <= IDLE;
                            req_q <= 1'b0;
                        end else begin
                            state <= REQ;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    // flush on jump wins over any same-cycle push or pop
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            count     <= 2'd0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            q_addr[0] <= '0;
            q_addr[1] <= '0;
            q_inst[0] <= NOP_INST;
            q_inst[1] <= NOP_INST;
        end else if (jump_ena_i) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) begin
                q_addr[wr_ptr] <= pc;
                q_inst[wr_ptr] <= imem.imem_rdata_i;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count_nxt;
        end
    end

    assert property (@(posedge clk) disable iff (arst)
        push |-> count != 2'd2);

    assign imem.imem_req_o  = req_q;
    assign imem.imem_addr_o = addr_q;
    assign inst_valid_o     = count != 2'd0;
    assign inst_o           = inst_valid_o ? q_inst[rd_ptr] : NOP_INST;
    assign inst_addr_o      = inst_valid_o ? q_addr[rd_ptr] : '0;

endmodule

// File: tb/tb_if_fetch.sv
// Randomized bench for if_fetch: memory responder plus program-order
// reference model feeding a scoreboard popped by an output monitor.
module tb_if_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        arst;
    logic        jump_ena_i;
    logic [31:0] jump_addr_i;
    logic [3:0]  hold_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;

    always #5 clk = ~clk;

    if_fetch_if bus ();

    if_fetch #(
        .RESET_PC(32'h0000_0000),
        .NOP_INST(NOP)
    ) dut (
        .clk          (clk),
        .arst         (arst),
        .jump_ena_i   (jump_ena_i),
        .jump_addr_i  (jump_addr_i),
        .hold_i       (hold_i),
        .imem         (bus.master),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .inst_valid_o (inst_valid_o)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] i;
        int          c;
    } ent_t;

    ent_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cycle = 0;
    int          consumed = 0;
    int          last_jump = -1;
    int          start_cyc = 0;
    int          wait_n = 0;
    bit          busy = 0;
    logic [31:0] req_addr;
    logic [31:0] model_pc = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    function automatic logic pct(input int p);
        return logic'($urandom_range(0, 99) < p);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cycle);
        end
    endtask

    // One cycle: random controls, memory response, reference-model update
    task automatic drive_cycle(input int lmin, input int lmax,
                               input int jp, input int h0, input int h1);
        bit stale;
        @(posedge clk);
        #1;
        cycle++;
        hold_i     = {2'($urandom_range(0, 3)), pct(h1), pct(h0)};
        jump_ena_i = pct(jp);
        if ($urandom_range(0, 3) == 0)
            jump_addr_i = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        else
            jump_addr_i = $urandom;
        bus.imem_ack_i   = 1'b0;
        bus.imem_rdata_i = $urandom;
        if (jump_ena_i) last_jump = cycle;
        if (bus.imem_req_o) begin
            if (!busy) begin
                busy      = 1;
                start_cyc = cycle;
                wait_n    = $urandom_range(lmin, lmax);
                req_addr  = bus.imem_addr_o;
            end else begin
                chk("addr_stable", bus.imem_addr_o, req_addr);
            end
            if (wait_n == 0) begin
                bus.imem_ack_i   = 1'b1;
                bus.imem_rdata_i = mem_word(bus.imem_addr_o);
                busy  = 0;
                stale = last_jump >= start_cyc;
                if (!stale) begin
                    chk("fetch_addr", bus.imem_addr_o, model_pc);
                    exp_q.push_back('{model_pc, mem_word(model_pc), cycle});
                    model_pc = model_pc + 32'd4;
                end
            end else begin
                wait_n--;
            end
        end else if (busy) begin
            chk("req_held", {31'b0, bus.imem_req_o}, 32'd1);
            busy = 0;
        end
        if (jump_ena_i) model_pc = {jump_addr_i[31:2], 2'b00};
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req", {31'b0, bus.imem_req_o}, 32'd0);
        chk("rst_addr", bus.imem_addr_o, 32'h0);
        chk("rst_inst", inst_o, NOP);
        chk("rst_inst_addr", inst_addr_o, 32'h0);
        chk("rst_valid", {31'b0, inst_valid_o}, 32'd0);
    endtask

    // Monitor: compare the presented head against the scoreboard
    always @(negedge clk) begin
        if (!arst) begin
            if (inst_valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", {31'b0, inst_valid_o}, 32'd0);
                end else begin
                    chk("inst_addr", inst_addr_o, exp_q[0].a);
                    chk("inst", inst_o, exp_q[0].i);
                end
            end else begin
                chk("nop_inst", inst_o, NOP);
                chk("nop_addr", inst_addr_o, 32'h0);
                if (exp_q.size() != 0 && exp_q[0].c < cycle)
                    chk("missing_valid", {31'b0, inst_valid_o}, 32'd1);
            end
            if (jump_ena_i) begin
                exp_q.delete();
            end else if (inst_valid_o && !hold_i[1] && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                consumed++;
            end
        end
    end

    initial begin
        int  base;
        bit  found;
        arst             = 1'b1;
        jump_ena_i       = 1'b0;
        jump_addr_i      = 32'h0;
        hold_i           = 4'h0;
        bus.imem_ack_i   = 1'b0;
        bus.imem_rdata_i = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs();
        arst = 1'b0;

        base = consumed;
        repeat (40) drive_cycle(0, 0, 0, 0, 0);
        chk("throughput", 32'(consumed - base >= 34), 32'd1);

        repeat (6) drive_cycle(0, 0, 0, 0, 100);
        chk("hold_idle_req", {31'b0, bus.imem_req_o}, 32'd0);
        chk("hold_full_valid", {31'b0, inst_valid_o}, 32'd1);

        repeat (30)  drive_cycle(2, 2, 0, 0, 0);
        repeat (60)  drive_cycle(0, 0, 0, 0, 60);
        repeat (300) drive_cycle(0, 2, 8, 20, 20);
        repeat (300) drive_cycle(1, 3, 15, 10, 10);
        repeat (300) drive_cycle(0, 1, 10, 0, 30);

        found = 0;
        for (int k = 0; k < 30 && !found; k++) begin
            drive_cycle(4, 4, 0, 0, 0);
            if (busy && wait_n > 0) found = 1;
        end
        chk("mid_req_found", {31'b0, found}, 32'd1);
        #2;
        arst = 1'b1;
        #1;
        chk_reset_outputs();
        exp_q.delete();
        busy           = 0;
        model_pc       = 32'h0;
        last_jump      = -1;
        bus.imem_ack_i = 1'b0;
        jump_ena_i     = 1'b0;
        hold_i         = 4'h0;
        @(posedge clk);
        #2;
        arst = 1'b0;

        repeat (40) drive_cycle(0, 1, 0, 0, 0);
        chk("progress", 32'(consumed > 150), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
